dcache_wb_line: RTL and testbench

- Parametrised successor to the single-word direct-mapped data cache. Write-back, write-allocate, direct-mapped, with multi-word lines.
- Misses refill a whole line. Dirty evictions write back a whole line, one word per beat, on the existing arbiter-side req/dok interface.
- A configurable uncached address window is served by single-beat transfers.
- Sits between the MIPS core data port and the memory arbiter.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_store.sv | 73 +++++++
 rtl/dcache_wb_line.sv | 195 +++++++++++++++++++
 tb/tb_dcache_wb_line.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back multi-word-line data cache.
// Holds the FSM state encoding and the helpers that slice a byte address into tag, index and word.
package dcache_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WB     = 3'd1;
   localparam logic [2:0] S_REFILL = 3'd2;
   localparam logic [2:0] S_UC_RD  = 3'd3;
   localparam logic [2:0] S_UC_WR  = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   function automatic int tag_bits(input int index_bits, input int offset_bits);
      return 30 - index_bits - offset_bits;
   endfunction

   function automatic int line_words(input int offset_bits);
      return 1 << offset_bits;
   endfunction

   // Each field helper returns the field right-aligned; callers size-cast it.
   function automatic logic [31:0] addr_word(input logic [31:0] addr, input int offset_bits);
      return (addr >> 2) & ((32'd1 << offset_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits,
                                              input int offset_bits);
      return (addr >> (offset_bits + 2)) & ((32'd1 << index_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits,
                                            input int offset_bits);
      return addr >> (index_bits + offset_bits + 2);
   endfunction

endpackage

// File: rtl/dcache_store.sv
// Line storage: per-line tag/valid/dirty plus per-word data, all in flops.
// Reads are asynchronous; word and metadata writes land at the clock edge.
module dcache_store
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS  = 7,
   parameter int OFFSET_BITS = 2,
   parameter int TAG_BITS    = 21
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INDEX_BITS-1:0]  rd_index,
   input  logic [OFFSET_BITS-1:0] rd_word,
   output logic [TAG_BITS-1:0]    rd_tag,
   output logic                   rd_valid,
   output logic                   rd_dirty,
   output logic [31:0]            rd_data,
   input  logic                   word_we,
   input  logic [INDEX_BITS-1:0]  word_index,
   input  logic [OFFSET_BITS-1:0] word_sel,
   input  logic [3:0]             word_be,
   input  logic [31:0]            word_data,
   input  logic                   meta_we,
   input  logic [INDEX_BITS-1:0]  meta_index,
   input  logic [TAG_BITS-1:0]    meta_tag,
   input  logic                   meta_valid,
   input  logic                   meta_dirty
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = line_words(OFFSET_BITS);

   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [31:0]         data_q [LINES*WORDS];
   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    dirty_q;
   logic [31:0]         old_word;
   logic [31:0]         merged_word;

   assign rd_tag   = tag_q[rd_index];
   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
   assign rd_data  = data_q[{rd_index, rd_word}];
   assign old_word = data_q[{word_index, word_sel}];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign merged_word[gi*8 +: 8] = word_be[gi] ? word_data[gi*8 +: 8] : old_word[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (word_we) begin
         data_q[{word_index, word_sel}] <= merged_word;
      end
      if (meta_we) begin
         tag_q[meta_index] <= meta_tag;
      end
   end

   // Only the state bits are reset; tags and data are don't-care while invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (meta_we) begin
         valid_q[meta_index] <= meta_valid;
         dirty_q[meta_index] <= meta_dirty;
      end
   end

endmodule

// File: rtl/dcache_wb_line.sv
// Write-back, write-allocate, direct-mapped data cache with multi-word lines between the
// core data port and the memory arbiter; an uncached window is passed through as single beats.
module dcache_wb_line
   import dcache_pkg::*;
#(
   parameter int          INDEX_BITS  = 7,
   parameter int          OFFSET_BITS = 2,
   parameter logic [15:0] UNCACHED_HI = 16'h1faf
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        d_cache_stall,
   output logic        data_cache_req,
   output logic [31:0] data_cache_addr,
   output logic [3:0]  data_cache_wen,
   output logic [31:0] data_cache_wdata,
   input  logic [31:0] data_cache_rdata,
   input  logic        data_cache_dok
);

   localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);

   logic [2:0]             state_q, state_d;
   logic [OFFSET_BITS-1:0] beat_q, beat_d;
   logic [31:0]            rdata_q, rdata_d;

   logic [TAG_BITS-1:0]    req_tag;
   logic [INDEX_BITS-1:0]  req_index;
   logic [OFFSET_BITS-1:0] req_word;
   logic [OFFSET_BITS-1:0] rd_word;
   logic [TAG_BITS-1:0]    line_tag;
   logic                   line_valid, line_dirty;
   logic [31:0]            line_data;
   logic                   uncached, hit, miss, last_beat;

   logic                   word_we, meta_we, meta_valid, meta_dirty;
   logic [OFFSET_BITS-1:0] word_sel;
   logic [3:0]             word_be;
   logic [31:0]            word_data;
   logic [TAG_BITS-1:0]    meta_tag;

   assign req_tag   = TAG_BITS'(addr_tag(data_sram_addr, INDEX_BITS, OFFSET_BITS));
   assign req_index = INDEX_BITS'(addr_index(data_sram_addr, INDEX_BITS, OFFSET_BITS));
   assign req_word  = OFFSET_BITS'(addr_word(data_sram_addr, OFFSET_BITS));
   assign uncached  = (data_sram_addr[31:16] == UNCACHED_HI);
   assign hit       = data_sram_en & ~uncached & line_valid & (line_tag == req_tag);
   assign miss      = data_sram_en & ~hit;
   assign last_beat = &beat_q;
   // Write-back streams the victim line, so the read port follows the beat counter there.
   assign rd_word   = (state_q == S_WB) ? beat_q : req_word;

   dcache_store #(
      .INDEX_BITS (INDEX_BITS),
      .OFFSET_BITS(OFFSET_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_store (
      .clk       (clk),
      .rst_n     (resetn),
      .rd_index  (req_index),
      .rd_word   (rd_word),
      .rd_tag    (line_tag),
      .rd_valid  (line_valid),
      .rd_dirty  (line_dirty),
      .rd_data   (line_data),
      .word_we   (word_we),
      .word_index(req_index),
      .word_sel  (word_sel),
      .word_be   (word_be),
      .word_data (word_data),
      .meta_we   (meta_we),
      .meta_index(req_index),
      .meta_tag  (meta_tag),
      .meta_valid(meta_valid),
      .meta_dirty(meta_dirty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (miss) begin
               if (uncached) state_d = (data_sram_wen == 4'b0000) ? S_UC_RD : S_UC_WR;
               else          state_d = (line_valid && line_dirty) ? S_WB : S_REFILL;
            end
         end
         // The counter wraps to zero on the last beat, ready for the next line.
         S_WB, S_REFILL: begin
            if (data_cache_dok) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = (state_q == S_WB) ? S_REFILL : S_IDLE;
            end
         end
         S_UC_RD: begin
            if (data_cache_dok) begin
               rdata_d = data_cache_rdata;
               state_d = S_RESP;
            end
         end
         S_UC_WR: if (data_cache_dok) state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      d_cache_stall    = 1'b0;
      data_cache_req   = 1'b0;
      data_cache_addr  = '0;
      data_cache_wen   = 4'b0000;
      data_cache_wdata = '0;
      data_sram_rdata  = rdata_q;
      word_we          = 1'b0;
      word_sel         = req_word;
      word_be          = 4'b0000;
      word_data        = '0;
      meta_we          = 1'b0;
      meta_tag         = req_tag;
      meta_valid       = 1'b0;
      meta_dirty       = 1'b0;
      case (state_q)
         S_IDLE: begin
            d_cache_stall = miss;
            if (hit) data_sram_rdata = line_data;
            if (hit && data_sram_wen != 4'b0000) begin
               word_we    = 1'b1;
               word_be    = data_sram_wen;
               word_data  = data_sram_wdata;
               meta_we    = 1'b1;
               meta_valid = 1'b1;
               meta_dirty = 1'b1;
            end
         end
         S_WB: begin
            d_cache_stall    = 1'b1;
            data_cache_req   = 1'b1;
            data_cache_wen   = 4'b1111;
            data_cache_addr  = {line_tag, req_index, beat_q, 2'b00};
            data_cache_wdata = line_data;
            if (data_cache_dok && last_beat) begin
               meta_we    = 1'b1;
               meta_tag   = line_tag;
               meta_valid = 1'b1;
            end
         end
         S_REFILL: begin
            d_cache_stall   = 1'b1;
            data_cache_req  = 1'b1;
            data_cache_addr = {req_tag, req_index, beat_q, 2'b00};
            if (data_cache_dok) begin
               word_we   = 1'b1;
               word_sel  = beat_q;
               word_be   = 4'b1111;
               word_data = data_cache_rdata;
               // The line becomes valid only once its final word has arrived.
               if (last_beat) begin
                  meta_we    = 1'b1;
                  meta_valid = 1'b1;
               end
            end
         end
         S_UC_RD: begin
            d_cache_stall   = 1'b1;
            data_cache_req  = 1'b1;
            data_cache_addr = data_sram_addr;
         end
         S_UC_WR: begin
            d_cache_stall    = 1'b1;
            data_cache_req   = 1'b1;
            data_cache_addr  = data_sram_addr;
            data_cache_wen   = data_sram_wen;
            data_cache_wdata = data_sram_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_wb_line.sv
// Directed bench for dcache_wb_line: refill, store hit, dirty eviction, uncached window,
// write miss and reset in the middle of a refill.
module tb_dcache_wb_line;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        req;
   logic [31:0] maddr;
   logic [3:0]  mwen;
   logic [31:0] mwdata;
   logic [31:0] mrdata;
   logic        dok;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dcache_wb_line dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .d_cache_stall   (stall),
      .data_cache_req  (req),
      .data_cache_addr (maddr),
      .data_cache_wen  (mwen),
      .data_cache_wdata(mwdata),
      .data_cache_rdata(mrdata),
      .data_cache_dok  (dok)
   );

   // Memory-side responder: waits (bounded) for req, captures the beat, then acknowledges after gap cycles.
   task automatic mem_beat(input int gap, input logic [31:0] rd, output logic [31:0] a,
                           output logic [3:0] w, output logic [31:0] wd, output bit to);
      for (int i = 0; i < 50 && !req; i++) @(negedge clk);
      to = !req;
      a  = maddr;
      w  = mwen;
      wd = mwdata;
      if (!to) begin
         repeat (gap) @(negedge clk);
         dok    = 1'b1;
         mrdata = rd;
         @(negedge clk);
         dok    = 1'b0;
      end
   endtask

   task automatic core_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      en    = 1'b1;
      addr  = a;
      wen   = w;
      wdata = d;
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; en = 1'b0; wen = '0; addr = '0; wdata = '0; dok = 1'b0; mrdata = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
      checks++; if (req !== 1'b0)    begin errors++; $display("FAIL reset_req got %b want 0", req); end
      checks++; if (mwen !== 4'h0)   begin errors++; $display("FAIL reset_wen got %h want 0", mwen); end
      checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", maddr); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
      $display("reset done");
   endtask

   task automatic test_cold_load();
      logic [31:0] a, wd; logic [3:0] w; bit to;
      int gaps [4] = '{1, 3, 1, 2};
      @(negedge clk);
      core_req(32'h0000_0104, 4'h0, 32'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cold_stall got %b want 1", stall); end
      for (int b = 0; b < 4; b++) begin
         mem_beat(gaps[b], 32'hA0 + b, a, w, wd, to);
         checks++; if (to || a !== 32'h100 + 4*b || w !== 4'h0)
            begin errors++; $display("FAIL cold_beat%0d got addr=%h wen=%h to=%0d want addr=%h wen=0", b, a, w, to, 32'h100 + 4*b); end
      end
      #1;
      checks++; if (stall !== 1'b0 || rdata !== 32'hA1)
         begin errors++; $display("FAIL cold_result got stall=%b rdata=%h want 0/000000a1", stall, rdata); end
      core_req(32'h0000_0108, 4'h0, 32'h0);
      checks++; if (stall !== 1'b0 || rdata !== 32'hA2)
         begin errors++; $display("FAIL hit_load got stall=%b rdata=%h want 0/000000a2", stall, rdata); end
      $display("load 0x104 refill, load 0x108 hit rdata=%h", rdata);
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_store_hit();
      @(negedge clk);
      core_req(32'h0000_0104, 4'b0010, 32'h0000_5500);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_hit_stall got %b want 0", stall); end
      @(negedge clk);
      core_req(32'h0000_0104, 4'h0, 32'h0);
      checks++; if (stall !== 1'b0 || rdata !== 32'h55A1)
         begin errors++; $display("FAIL store_merge got stall=%b rdata=%h want 0/000055a1", stall, rdata); end
      $display("store 0x104 wen=0010, reload rdata=%h", rdata);
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_conflict();
      logic [31:0] a, wd; logic [3:0] w; bit to;
      logic [31:0] wb_exp [4] = '{32'hA0, 32'h55A1, 32'hA2, 32'hA3};
      @(negedge clk);
      core_req(32'h0000_2104, 4'h0, 32'h0);
      for (int b = 0; b < 4; b++) begin
         mem_beat(1 + b % 2, 32'h0, a, w, wd, to);
         checks++; if (to || a !== 32'h100 + 4*b || w !== 4'hF || wd !== wb_exp[b])
            begin errors++; $display("FAIL wb_beat%0d got addr=%h wen=%h wdata=%h want %h/f/%h", b, a, w, wd, 32'h100 + 4*b, wb_exp[b]); end
      end
      for (int b = 0; b < 4; b++) begin
         mem_beat(1, 32'hB0 + b, a, w, wd, to);
         checks++; if (to || a !== 32'h2100 + 4*b || w !== 4'h0)
            begin errors++; $display("FAIL conflict_refill%0d got addr=%h wen=%h want %h/0", b, a, w, 32'h2100 + 4*b); end
      end
      #1;
      checks++; if (stall !== 1'b0 || rdata !== 32'hB1)
         begin errors++; $display("FAIL conflict_result got stall=%b rdata=%h want 0/000000b1", stall, rdata); end
      $display("load 0x2104 evict+refill rdata=%h", rdata);
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_uncached_load();
      logic [31:0] a, wd; logic [3:0] w; bit to;
      @(negedge clk);
      core_req(32'h1FAF_F000, 4'h0, 32'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL uc_rd_stall got %b want 1", stall); end
      mem_beat(2, 32'hDEAD_BEEF, a, w, wd, to);
      checks++; if (to || a !== 32'h1FAF_F000 || w !== 4'h0)
         begin errors++; $display("FAIL uc_rd_beat got addr=%h wen=%h want 1faff000/0", a, w); end
      #1;
      checks++; if (stall !== 1'b0 || req !== 1'b0 || rdata !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL uc_rd_resp got stall=%b req=%b rdata=%h want 0/0/deadbeef", stall, req, rdata); end
      en = 1'b0;
      @(negedge clk);
      core_req(32'h0000_2104, 4'h0, 32'h0);
      checks++; if (stall !== 1'b0 || rdata !== 32'hB1)
         begin errors++; $display("FAIL uc_rd_line_kept got stall=%b rdata=%h want 0/000000b1", stall, rdata); end
      $display("uncached load 0x1faff000 rdata=deadbeef");
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_uncached_store();
      logic [31:0] a, wd; logic [3:0] w; bit to;
      @(negedge clk);
      core_req(32'h1FAF_0010, 4'b0011, 32'h1234_5678);
      mem_beat(1, 32'h0, a, w, wd, to);
      checks++; if (to || a !== 32'h1FAF_0010 || w !== 4'b0011 || wd !== 32'h1234_5678)
         begin errors++; $display("FAIL uc_wr_beat got addr=%h wen=%h wdata=%h want 1faf0010/3/12345678", a, w, wd); end
      #1;
      checks++; if (stall !== 1'b0 || req !== 1'b0)
         begin errors++; $display("FAIL uc_wr_resp got stall=%b req=%b want 0/0", stall, req); end
      en = 1'b0;
      @(negedge clk);
      core_req(32'h0000_210C, 4'h0, 32'h0);
      checks++; if (stall !== 1'b0 || rdata !== 32'hB3)
         begin errors++; $display("FAIL uc_wr_line_kept got stall=%b rdata=%h want 0/000000b3", stall, rdata); end
      $display("uncached store 0x1faf0010 wen=0011");
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_write_miss();
      logic [31:0] a, wd; logic [3:0] w; bit to;
      @(negedge clk);
      core_req(32'h0000_3008, 4'hF, 32'hCAFE_F00D);
      for (int b = 0; b < 4; b++) begin
         mem_beat(1, 32'hC0 + b, a, w, wd, to);
         checks++; if (to || a !== 32'h3000 + 4*b || w !== 4'h0)
            begin errors++; $display("FAIL wmiss_refill%0d got addr=%h wen=%h want %h/0", b, a, w, 32'h3000 + 4*b); end
      end
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wmiss_stall got %b want 0", stall); end
      @(negedge clk);
      core_req(32'h0000_3008, 4'h0, 32'h0);
      checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wmiss_store got %h want cafef00d", rdata); end
      core_req(32'h0000_300C, 4'h0, 32'h0);
      checks++; if (rdata !== 32'hC3) begin errors++; $display("FAIL wmiss_neighbour got %h want 000000c3", rdata); end
      $display("store miss 0x3008 refill+merge rdata=%h", rdata);
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] a, wd; logic [3:0] w; bit to;
      @(negedge clk);
      core_req(32'h0000_4040, 4'h0, 32'h0);
      for (int b = 0; b < 2; b++) mem_beat(1, 32'hE0 + b, a, w, wd, to);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL abort_pre_req got %b want 1", req); end
      resetn = 1'b0;
      #1;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL abort_req got %b want 0", req); end
      en = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      core_req(32'h0000_4040, 4'h0, 32'h0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_remiss got stall=%b want 1", stall); end
      for (int b = 0; b < 4; b++) begin
         mem_beat(1, 32'hF0 + b, a, w, wd, to);
         checks++; if (to || a !== 32'h4040 + 4*b)
            begin errors++; $display("FAIL abort_refill%0d got addr=%h to=%0d want %h", b, a, to, 32'h4040 + 4*b); end
      end
      #1;
      checks++; if (stall !== 1'b0 || rdata !== 32'hF0)
         begin errors++; $display("FAIL abort_result got stall=%b rdata=%h want 0/000000f0", stall, rdata); end
      $display("reset mid-refill 0x4040, reload rdata=%h", rdata);
      @(negedge clk); en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_store_hit();
      test_conflict();
      test_uncached_load();
      test_uncached_store();
      test_write_miss();
      test_reset_mid_refill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
